// File: rtl/fetch_buffer_pkg.sv
// rtl/fetch_buffer_pkg.sv - shared fetch/decode sizing and the IF_ID_PACKET type
// Purpose: one place where fetch, the fetch buffer and dispatch agree on
//          superscalar width, datapath width and fetch buffer depth.
// Contents: N, XLEN, FETCH_BUF_DEPTH, DN_BITS, IF_ID_PACKET.
package fetch_buffer_pkg;

  localparam int N               = 3;
  localparam int XLEN            = 32;
  localparam int FETCH_BUF_DEPTH = 16;
  // Width of a 0..N packet count (dispatch_num, per-slot offsets, k).
  localparam int DN_BITS         = $clog2(N + 1);

  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
  } IF_ID_PACKET;

endpackage

// File: rtl/fetch_buffer_compact.sv
// rtl/fetch_buffer_compact.sv - prefix popcount of N valid bits (fb_compact)
// Purpose: maps per-slot valid bits to dense write offsets so valid packets
//          land in consecutive queue entries in slot order.
// Ports:   valid  in  [N-1:0]        per-slot valid bits, may be sparse
//          offset out [DN_BITS-1:0]  per slot: number of valid slots below it
//          k      out [DN_BITS-1:0]  total number of valid slots
module fb_compact
  import fetch_buffer_pkg::*;
(
  input  logic [N-1:0]       valid,
  output logic [DN_BITS-1:0] offset [N],
  output logic [DN_BITS-1:0] k
);

  logic [DN_BITS-1:0] run;

  always_comb begin
    run = '0;
    for (int i = 0; i < N; i++) begin
      offset[i] = run;
      run       = run + DN_BITS'(valid[i]);
    end
    k = run;
  end

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - N-wide circular instruction queue between fetch and decode
// Purpose: absorbs up to N compacted fetch packets per cycle, presents the
//          oldest N to decode, retires what dispatch consumes, flushes on nuke.
// Ports:   clock          in   system clock
//          reset          in   asynchronous active-low reset
//          nuke           in   mispredict flush, empties the queue
//          if_packet_in   in   fetch group (N packets, sparse valid bits)
//          dispatch_num   in   head entries consumed this cycle (0..N)
//          fetch_stall    out  fewer than N free entries; fetch holds its group
//          id_packet_out  out  oldest N entries, slot 0 oldest
//          occupancy      out  current entry count
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH    = FETCH_BUF_DEPTH,
  parameter int PTR_BITS = $clog2(DEPTH),
  parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                nuke,
  input  IF_ID_PACKET         if_packet_in [N],
  input  logic [DN_BITS-1:0]  dispatch_num,
  output logic                fetch_stall,
  output IF_ID_PACKET         id_packet_out [N],
  output logic [CNT_BITS-1:0] occupancy
);

  localparam logic [CNT_BITS:0] DEPTH_W = (CNT_BITS + 1)'(DEPTH);
  localparam logic [CNT_BITS:0] N_W     = (CNT_BITS + 1)'(N);

  IF_ID_PACKET         mem [DEPTH];
  logic [DEPTH-1:0]    entry_valid;
  logic [PTR_BITS-1:0] head;
  logic [PTR_BITS-1:0] tail;
  logic [CNT_BITS-1:0] count;

  logic [N-1:0]        in_valid;
  logic [DN_BITS-1:0]  offset [N];
  logic [DN_BITS-1:0]  k;
  logic                push;
  logic [DN_BITS-1:0]  push_num;
  logic [DN_BITS-1:0]  pop_num;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_valid[i] = if_packet_in[i].valid;
    end
  end

  fb_compact u_compact (
    .valid  (in_valid),
    .offset (offset),
    .k      (k)
  );

  // Stall uses the registered count only, so a same-cycle pop never frees
  // room for a push; this keeps push and pop entries disjoint.
  assign fetch_stall = (DEPTH_W - {1'b0, count}) < N_W;
  assign push        = ~fetch_stall & ~nuke;
  assign push_num    = push ? k : '0;
  // Over-asking dispatch is clamped so head never passes tail.
  assign pop_num     = (CNT_BITS'(dispatch_num) > count) ? DN_BITS'(count) : dispatch_num;
  assign occupancy   = count;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      id_packet_out[i]       = mem[PTR_BITS'(head + PTR_BITS'(i))];
      id_packet_out[i].valid = entry_valid[PTR_BITS'(head + PTR_BITS'(i))]
                               && (CNT_BITS'(i) < count) && !nuke;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else if (nuke) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      head  <= head + PTR_BITS'(pop_num);
      tail  <= tail + PTR_BITS'(push_num);
      count <= count + CNT_BITS'(push_num) - CNT_BITS'(pop_num);
      for (int i = 0; i < N; i++) begin
        if (DN_BITS'(i) < pop_num) begin
          entry_valid[PTR_BITS'(head + PTR_BITS'(i))] <= 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (push && in_valid[i]) begin
          entry_valid[PTR_BITS'(tail + PTR_BITS'(offset[i]))] <= 1'b1;
        end
      end
    end
  end

  // Payload storage needs no reset: visibility is governed by entry_valid and count.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (push && in_valid[i]) begin
        mem[PTR_BITS'(tail + PTR_BITS'(offset[i]))] <= if_packet_in[i];
      end
    end
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- N-wide circular instruction queue between the fetch stage and id_stage.
- Each cycle it absorbs up to N IF_ID_PACKETs from fetch. Valid packets are compacted in program order.
- It presents the oldest N entries to decode/dispatch and retires however many the downstream consumes.
- It decouples fetch from dispatch stalls (ROB/RS full, no_free_prf) and flushes on nuke.

Parameters:
- N, `N, superscalar width (packets in and out per cycle).
- DEPTH, 16, queue entries; must be a power of 2 and >= 2*N.
- PTR_BITS, $clog2(DEPTH), head/tail pointer width.
- CNT_BITS, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- nuke  in  1  mispredict flush from ROB; empties the queue.
- if_packet_in  in  IF_ID_PACKET[N]  fetch group; per-slot .valid bits may be non-contiguous.
- dispatch_num  in  $clog2(N+1)  number of head entries consumed this cycle (0..N).
- fetch_stall  out  1  high when free slots < N; fetch must hold its group.
- id_packet_out  out  IF_ID_PACKET[N]  oldest N entries; slot 0 is the oldest.
- occupancy  out  CNT_BITS  current entry count (debug and visual debugger).

Behaviour:
- Reset (reset==0, async):
  - head=0, tail=0, count=0.
  - All entry .valid bits cleared; fetch_stall=0; occupancy=0.
  - All id_packet_out[i].valid=0.
- Storage: DEPTH entries of IF_ID_PACKET, addressed modulo DEPTH. Pointers wrap naturally at PTR_BITS.
- Output read (combinational, zero latency):
  - id_packet_out[i] = entry[(head+i) mod DEPTH].
  - .valid forced to (i < count) && ~nuke; other fields pass through unchanged.
- Stall: fetch_stall = (DEPTH - count) < N, computed from the registered count, before this cycle's pop.
  - Conservative by design: no bypass of same-cycle pops.
- Push (when ~fetch_stall && ~nuke):
  - k = popcount of if_packet_in[*].valid.
  - Valid packets are written in slot order to entry[(tail+j) mod DEPTH], j=0..k-1. Invalid slots are skipped (compaction).
  - tail += k.
  - When fetch_stall=1, the whole group is dropped. Fetch is responsible for re-presenting it.
- Pop:
  - p = min(dispatch_num, count); a dispatch_num > count is clamped to count, and the bench asserts it never occurs.
  - head += p.
  - Popped entries' valid bits are cleared.
- Simultaneous push and pop in the same cycle:
  - count_next = count + k - p.
  - Push and pop never alias because the stall check uses the pre-pop count.
- Nuke (synchronous, highest priority after reset):
  - On the clock edge with nuke=1: head=tail=count=0, all entry valids cleared, push and pop ignored.
  - During the nuke cycle the outputs show invalid.
  - The cycle after nuke, the buffer is empty and fetch_stall=0.
- Full (count==DEPTH): fetch_stall=1; a pop of p still occurs, and the next cycle stalls only if DEPTH-(DEPTH-p) < N.
- Empty (count==0): all outputs invalid; dispatch_num is treated as 0.
- Wrap-around: a group that straddles entry DEPTH-1 and entry 0 is written and read in correct order.
- Reset asserted mid-operation: immediate clear regardless of clock; no partial writes survive.
- No illegal or X states: count is always <= DEPTH.

Decomposition:
- Shared package (sys_defs): IF_ID_PACKET, `N, `XLEN.
  - Add a FETCH_BUF_DEPTH define there so fetch and dispatch agree on sizing.
- One natural sub-module: fb_compact.
  - Purely combinational; maps the N input valid bits to per-slot write offsets (prefix popcount) and outputs k.
  - Reused later by dispatch logic.
- Pointer, counter and storage logic live in fetch_buffer itself.

Test Plan (N=3, DEPTH=16):
- Reset then idle: reset low for 2 cycles, then release. Expect occupancy=0, fetch_stall=0, all id_packet_out valid=0.
- Compaction: push valid={1,0,1} with PCs 0x100/0x104/0x108 and dispatch_num=0. Next cycle expect occupancy=2, out[0].PC=0x100, out[1].PC=0x108, out[2].valid=0.
- Fill to stall: 5 pushes of 3 with no pops give occupancy=15. Expect fetch_stall=1. A 6th group is dropped and occupancy stays 15.
- Simultaneous push and pop: at occupancy=6, push 3 with dispatch_num=2. Next cycle expect occupancy=7, and out[0] is the third-oldest entry.
- Wrap-around: drive head/tail to 14 via push/pop, then push 3 (PCs 0x200..0x208). Expect entries at indices 14, 15, 0; reading back with dispatch_num=3 returns 0x200, 0x204, 0x208 in order.
- Nuke: at occupancy=9, assert nuke together with a push of 3 and dispatch_num=3. That cycle outputs are invalid; next cycle occupancy=0 and fetch_stall=0. Also check that async reset asserted mid-clock clears occupancy immediately.
